// File: rtl/service_4_alarm_set.sv
// service_4_alarm_set: push-button editor for the packed-BCD alarm time (HHMM).
// Edits go into a shadow copy and reach `alarm` only on commit. The switch
// SPDT4 locks editing and aborts any edit in progress. A timeout also
// abandons an edit.
// Optional feature macro: ALARM_SET_AUTOREPEAT_EN adds hold-to-repeat stepping.
// Without the macro, only press edges step and HOLD_CYCLES/REPEAT_CYCLES are unused.
module service_4_alarm_set #(
    parameter int HOLD_CYCLES    = 50_000_000,
    parameter int REPEAT_CYCLES  = 10_000_000,
    parameter int TIMEOUT_CYCLES = 500_000_000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        SPDT4,
    input  logic        push_u,
    input  logic        push_d,
    input  logic        push_c,
    output logic [15:0] alarm,
    output logic [15:0] shadow,
    output logic [1:0]  edit_mode,
    output logic        commit,
    output logic        alarm_set
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        EDIT_HR  = 2'b01,
        EDIT_MIN = 2'b10
    } state_t;

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [31:0] to_cnt;
    logic        prev_u;
    logic        prev_d;
    logic        prev_c;
    logic        press_u;
    logic        press_d;
    logic        press_c;
    logic        step_up;
    logic        step_dn;
    logic        to_expire;

    // BCD increment of a two-digit field that wraps from top to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
        logic [7:0] r;
        if (v == top)
            r = 8'h00;
        else if (v[3:0] == 4'h9)
            r = {v[7:4] + 4'h1, 4'h0};
        else
            r = {v[7:4], v[3:0] + 4'h1};
        return r;
    endfunction

    // BCD decrement of a two-digit field that wraps from 00 to top.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] top);
        logic [7:0] r;
        if (v == 8'h00)
            r = top;
        else if (v[3:0] == 4'h0)
            r = {v[7:4] - 4'h1, 4'h9};
        else
            r = {v[7:4], v[3:0] - 4'h1};
        return r;
    endfunction

    // A press is a rising edge. Up and down cancel each other when both are high.
    assign press_c   = push_c & ~prev_c;
    assign press_u   = push_u & ~prev_u & ~push_d;
    assign press_d   = push_d & ~prev_d & ~push_u;
    assign to_expire = (to_cnt == TO_LAST);
    assign edit_mode = state;

`ifdef ALARM_SET_AUTOREPEAT_EN
    localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYCLES - 1);
    localparam logic [31:0] REP_LAST  = 32'(REPEAT_CYCLES - 1);

    logic [31:0] hold_cnt;
    logic        repeating;
    logic        editing;
    logic        state_change;
    logic        hold_run;
    logic        rep_fire;

    assign editing      = (state != IDLE);
    assign state_change = editing & (SPDT4 | press_c | to_expire);
    // Counting needs one button held alone past its press edge, with no state change.
    assign hold_run     = editing & ~state_change & (push_u ^ push_d) &
                          (push_u ? prev_u : prev_d);
    assign rep_fire     = hold_run & (repeating ? (hold_cnt == REP_LAST)
                                                : (hold_cnt == HOLD_LAST));
    assign step_up      = press_u | (rep_fire & push_u);
    assign step_dn      = press_d | (rep_fire & push_d);

    // Hold counter: first gap is HOLD_CYCLES, later gaps are REPEAT_CYCLES.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            hold_cnt  <= 32'd0;
            repeating <= 1'b0;
        end else if (!hold_run) begin
            hold_cnt  <= 32'd0;
            repeating <= 1'b0;
        end else if (rep_fire) begin
            hold_cnt  <= 32'd0;
            repeating <= 1'b1;
        end else begin
            hold_cnt  <= hold_cnt + 32'd1;
        end
    end
`else
    assign step_up = press_u;
    assign step_dn = press_d;
`endif

    // Previous-value flops for button edge detection.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            prev_u <= 1'b0;
            prev_d <= 1'b0;
            prev_c <= 1'b0;
        end else begin
            prev_u <= push_u;
            prev_d <= push_d;
            prev_c <= push_c;
        end
    end

    // Edit FSM. Priority order: lock/abort, select/commit, timeout, then stepping.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state     <= IDLE;
            alarm     <= 16'h0000;
            shadow    <= 16'h0000;
            commit    <= 1'b0;
            alarm_set <= 1'b0;
            to_cnt    <= 32'd0;
        end else begin
            commit <= 1'b0;
            case (state)
                IDLE: begin
                    to_cnt <= 32'd0;
                    if (press_c && !SPDT4) begin
                        state  <= EDIT_HR;
                        shadow <= alarm;
                    end
                end
                EDIT_HR, EDIT_MIN: begin
                    if (SPDT4) begin
                        state  <= IDLE;
                        shadow <= alarm;
                        to_cnt <= 32'd0;
                    end else if (press_c) begin
                        to_cnt <= 32'd0;
                        if (state == EDIT_HR) begin
                            state <= EDIT_MIN;
                        end else begin
                            state     <= IDLE;
                            alarm     <= shadow;
                            commit    <= 1'b1;
                            alarm_set <= 1'b1;
                        end
                    end else if (to_expire) begin
                        state  <= IDLE;
                        shadow <= alarm;
                        to_cnt <= 32'd0;
                    end else if (step_up || step_dn) begin
                        to_cnt <= 32'd0;
                        if (state == EDIT_HR)
                            shadow[15:8] <= step_up ? bcd_inc(shadow[15:8], 8'h23)
                                                    : bcd_dec(shadow[15:8], 8'h23);
                        else
                            shadow[7:0]  <= step_up ? bcd_inc(shadow[7:0], 8'h59)
                                                    : bcd_dec(shadow[7:0], 8'h59);
                    end else begin
                        to_cnt <= to_cnt + 32'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    shadow <= alarm;
                    to_cnt <= 32'd0;
                end
            endcase
        end
    end

endmodule
